// File: rtl/wb_master_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
//   arb_state_e  : FSM state encoding (IDLE / OWN0 / OWN1)
//   wb_req_t     : master-side request payload muxed onto the shared bus
//   TIMEOUT_FILL : read data returned to a master on forced completion
package wb_master_arbiter_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned GNT_W = 2;

  localparam logic [DAT_W-1:0] TIMEOUT_FILL = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
    logic             we;
    logic             stb;
    logic             cyc;
  } wb_req_t;

  // One-hot owner view of a state (bit0 = m0, bit1 = m1).
  function automatic logic [GNT_W-1:0] gnt_of(input arb_state_e s);
    logic [GNT_W-1:0] g;
    g = '0;
    case (s)
      ST_OWN0: g = 2'b01;
      ST_OWN1: g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: m0 (FSMC handler) and m1 (UART/host handler)
// share one slave bus. A master owns the bus for as long as it holds cyc;
// ties from IDLE go to the master not served last, and one dead IDLE cycle
// separates owners. Bus and response paths are combinational pass-through.
//
// Optional feature (macro WB_ARB_TIMEOUT_EN): a stall counter forces an
// ack with read data 32'hFFFFFFFF after TIMEOUT_CYCLES un-acked stb cycles.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   m{0,1}_adr/dat/sel/cyc/stb/we_i master requests
//   m{0,1}_dat_o, m{0,1}_ack_o      responses (owner only, else 0)
//   s_adr/dat/sel/cyc/stb/we_o      shared bus (0 in IDLE)
//   s_dat_i, s_ack_i                slave response
//   gnt_o                           one-hot owner (registered)
//   timeout_o                       one-cycle forced-completion pulse
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic [DAT_W-1:0] m0_dat_o,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  output logic             m0_ack_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic [DAT_W-1:0] m1_dat_o,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  output logic             m1_ack_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,
  output logic [GNT_W-1:0] gnt_o,
  output logic             timeout_o
);

  // Reject out-of-range timeout settings at elaboration.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_master_arbiter: TIMEOUT_CYCLES must be 1..255");
  end

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;   // 0 = m0 served last, 1 = m1
  logic             rdy_q;            // holds off grants for one edge after reset
  logic [GNT_W-1:0] gnt_q, gnt_d;
  logic             to_fire;          // forced completion in this cycle

  wb_req_t m0_req, m1_req, bus_c;

  assign m0_req = '{adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i,
                    we: m0_we_i, stb: m0_stb_i, cyc: m0_cyc_i};
  assign m1_req = '{adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i,
                    we: m1_we_i, stb: m1_stb_i, cyc: m1_cyc_i};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      rdy_q   <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rdy_q   <= 1'b1;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state: ownership held while the owner keeps cyc high.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (rdy_q) begin
          if (m0_cyc_i && m1_cyc_i) begin
            state_d = last_q ? ST_OWN0 : ST_OWN1;
          end else if (m0_cyc_i) begin
            state_d = ST_OWN0;
          end else if (m1_cyc_i) begin
            state_d = ST_OWN1;
          end
        end
      end
      ST_OWN0: begin
        if (!m0_cyc_i) begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
        end
      end
      ST_OWN1: begin
        if (!m1_cyc_i) begin
          state_d = ST_IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    gnt_d = gnt_of(state_d);
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             own_stb;

  // Stall counter: counts owner stb cycles with no slave ack.
  always_comb begin
    own_stb = 1'b0;
    case (state_q)
      ST_OWN0: own_stb = m0_stb_i;
      ST_OWN1: own_stb = m1_stb_i;
      default: own_stb = 1'b0;
    endcase
    cnt_d = cnt_q;
    if (state_d != state_q || to_q || !own_stb || s_ack_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Limit reached at this edge: force completion in the following cycle.
    to_d = (cnt_d == TO_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign to_fire = to_q;
`else
  assign to_fire = 1'b0;
`endif

  assign timeout_o = to_fire;
  assign gnt_o     = gnt_q;

  // Output mux: owner drives the bus and sees the slave response.
  always_comb begin
    bus_c    = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    case (state_q)
      ST_OWN0: begin
        bus_c    = m0_req;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
        if (to_fire) begin
          bus_c.stb = 1'b0;
          bus_c.cyc = 1'b0;
          m0_ack_o  = 1'b1;
          m0_dat_o  = TIMEOUT_FILL;
        end
      end
      ST_OWN1: begin
        bus_c    = m1_req;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
        if (to_fire) begin
          bus_c.stb = 1'b0;
          bus_c.cyc = 1'b0;
          m1_ack_o  = 1'b1;
          m1_dat_o  = TIMEOUT_FILL;
        end
      end
      default: ;
    endcase
  end

  assign s_adr_o = bus_c.adr;
  assign s_dat_o = bus_c.dat;
  assign s_sel_o = bus_c.sel;
  assign s_we_o  = bus_c.we;
  assign s_stb_o = bus_c.stb;
  assign s_cyc_o = bus_c.cyc;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: two master driver tasks, a slave responder,
// and a negedge monitor holding a rule-level model of ownership plus a
// per-master scoreboard of expected beat responses.
module tb_wb_master_arbiter;

  localparam int unsigned TCYC = 4;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] rdata;
    logic        to;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        mcyc [2];
  logic        mstb [2];
  logic        mwe  [2];
  logic [31:0] madr [2];
  logic [31:0] mdat [2];
  logic [3:0]  msel [2];
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [1:0]  gnt_o;
  logic        timeout_o;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   slave_delay;
  bit   slave_mute;
  int   to_seen = 0;

  wb_master_arbiter #(.TIMEOUT_CYCLES(TCYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]), .m0_dat_o(m0_dat_o), .m0_sel_i(msel[0]),
    .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]), .m0_ack_o(m0_ack_o),
    .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]), .m1_dat_o(m1_dat_o), .m1_sel_i(msel[1]),
    .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]), .m1_ack_o(m1_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] slave_data(input logic [31:0] adr);
    if (adr == 32'h0000_1234) return 32'hFEDC_BA98;
    return adr ^ 32'hC3C3_3C3C;
  endfunction

  // Slave: acks each strobed beat after 0..3 wait cycles (or a fixed delay).
  initial begin : slave
    int swait;
    swait   = -1;
    s_ack_i = 1'b0;
    s_dat_i = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      s_ack_i = 1'b0;
      if (s_cyc_o && s_stb_o && !slave_mute) begin
        if (swait < 0) swait = (slave_delay >= 0) ? slave_delay : int'($urandom_range(0, 3));
        if (swait == 0) begin
          s_ack_i = 1'b1;
          s_dat_i = slave_data(s_adr_o);
          swait   = -1;
        end else begin
          swait--;
        end
      end else begin
        swait = -1;
      end
    end
  end

  // One master cycle of nbeats beats; expectation pushed when each beat is issued.
  task automatic run_master(input int m, input int dly, input int nbeats,
                            input logic [31:0] adr0, input int we_mode,
                            input logic [31:0] dat0, input bit rnd, input bit to);
    exp_t e;
    bit   got;
    int   n;
    repeat (dly) @(posedge clk);
    @(posedge clk);
    #1;
    mcyc[m] = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      madr[m] = rnd ? 32'($urandom) : adr0 + 32'(4 * b);
      mdat[m] = rnd ? 32'($urandom) : dat0;
      msel[m] = rnd ? 4'($urandom) : 4'hF;
      mwe[m]  = (we_mode == 2) ? 1'($urandom) : 1'(we_mode);
      mstb[m] = 1'b1;
      e.adr   = madr[m];
      e.dat   = mdat[m];
      e.sel   = msel[m];
      e.we    = mwe[m];
      e.rdata = to ? 32'hFFFF_FFFF : slave_data(madr[m]);
      e.to    = to;
      if (m == 0) q0.push_back(e);
      else        q1.push_back(e);
      got = 1'b0;
      n   = 0;
      while (!got && n < 400) begin
        @(negedge clk);
        n++;
        got = (m == 0) ? m0_ack_o : m1_ack_o;
      end
      if (!got) begin
        n_cmp++;
        n_err++;
        $display("FAIL ack_wait m%0d: got no ack in 400 cycles, required ack", m);
      end
      @(posedge clk);
      #1;
      if (rnd && b < nbeats - 1 && $urandom_range(0, 1) == 1) begin
        mstb[m] = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    mstb[m] = 1'b0;
    mcyc[m] = 1'b0;
  endtask

  // Monitor: rule-level ownership model and response scoreboard.
  initial begin : monitor
    int          own_m, last_m, wait_m, x, nxt;
    bit          post_rst, forced_m, fnext;
    logic        ack_x;
    logic [31:0] dat_x;
    exp_t        e;
    own_m = 0; last_m = 1; wait_m = 0; post_rst = 1'b1; forced_m = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs", 160'({gnt_o, timeout_o, m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o}), 160'(0));
        chk("reset_bus", 160'({s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o}), 160'(0));
        own_m = 0; last_m = 1; wait_m = 0; post_rst = 1'b1; forced_m = 1'b0;
      end else begin
        chk("gnt", 160'(gnt_o), 160'((own_m == 1) ? 2'b01 : (own_m == 2) ? 2'b10 : 2'b00));
        if (timeout_o) to_seen++;
        if (own_m == 0) begin
          chk("idle_bus", 160'({s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o, timeout_o}), 160'(0));
          chk("idle_resp", 160'({m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o}), 160'(0));
        end else begin
          x     = own_m - 1;
          ack_x = (x == 0) ? m0_ack_o : m1_ack_o;
          dat_x = (x == 0) ? m0_dat_o : m1_dat_o;
          chk("nonowner_resp", 160'((x == 0) ? {m1_ack_o, m1_dat_o} : {m0_ack_o, m0_dat_o}), 160'(0));
          if (forced_m) begin
            chk("forced_completion", 160'({ack_x, dat_x, s_cyc_o, s_stb_o, timeout_o}),
                160'({1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1}));
          end else begin
            chk("bus_mux", 160'({s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o}),
                160'({madr[x], mdat[x], msel[x], mcyc[x], mstb[x], mwe[x]}));
            chk("owner_resp", 160'({ack_x, dat_x, timeout_o}), 160'({s_ack_i, s_dat_i, 1'b0}));
          end
          if (ack_x) begin
            if ((x == 0 && q0.size() == 0) || (x == 1 && q1.size() == 0)) begin
              n_cmp++;
              n_err++;
              $display("FAIL sb_unexpected_ack m%0d: got ack, required none", x);
            end else begin
              if (x == 0) e = q0.pop_front();
              else        e = q1.pop_front();
              chk("sb_rdata", 160'(dat_x), 160'(e.rdata));
              chk("sb_timeout_flag", 160'(timeout_o), 160'(e.to));
              if (!e.to)
                chk("sb_beat", 160'({s_adr_o, s_sel_o, s_we_o, e.we ? s_dat_o : 32'h0}),
                    160'({e.adr, e.sel, e.we, e.we ? e.dat : 32'h0}));
            end
          end
        end
        // Next owner from this cycle's requests.
        if (post_rst) begin
          nxt = 0;
          post_rst = 1'b0;
        end else if (own_m == 0) begin
          if (mcyc[0] && mcyc[1]) nxt = (last_m == 1) ? 1 : 2;
          else if (mcyc[0])       nxt = 1;
          else if (mcyc[1])       nxt = 2;
          else                    nxt = 0;
        end else if (mcyc[own_m-1]) begin
          nxt = own_m;
        end else begin
          nxt    = 0;
          last_m = own_m - 1;
        end
        fnext = 1'b0;
        if (nxt != own_m || own_m == 0 || forced_m) begin
          wait_m = 0;
        end else if (mstb[own_m-1] && !s_ack_i) begin
          wait_m++;
          fnext = TO_EN && (wait_m == int'(TCYC));
        end else begin
          wait_m = 0;
        end
        own_m    = nxt;
        forced_m = fnext;
      end
    end
  end

  initial begin : stimulus
    int d0, d1, n0, n1;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mcyc[i] = 1'b0; mstb[i] = 1'b0; mwe[i] = 1'b0;
      madr[i] = 32'h0; mdat[i] = 32'h0; msel[i] = 4'h0;
    end
    slave_delay = -1;
    slave_mute  = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Simultaneous request right after reset: m0 first, then m1.
    fork
      run_master(0, 0, 1, 32'h0000_0100, 1, 32'h0000_0011, 1'b0, 1'b0);
      run_master(1, 0, 1, 32'h0000_0200, 0, 32'h0, 1'b0, 1'b0);
    join

    // m0 write with a 3-cycle slave wait.
    slave_delay = 3;
    run_master(0, 0, 1, 32'h0000_AAAA, 1, 32'h0000_5555, 1'b0, 1'b0);
    slave_delay = -1;

    // m1 read of a fixed location.
    run_master(1, 0, 1, 32'h0000_1234, 0, 32'h0, 1'b0, 1'b0);

    // m0 4-beat burst while m1 requests.
    fork
      run_master(0, 0, 4, 32'h0000_3000, 1, 32'h0000_D0D0, 1'b0, 1'b0);
      run_master(1, 1, 1, 32'h0000_4000, 0, 32'h0, 1'b0, 1'b0);
    join

    // Randomized contention.
    repeat (40) begin
      d0 = int'($urandom_range(0, 3)); d1 = int'($urandom_range(0, 3));
      n0 = int'($urandom_range(1, 4)); n1 = int'($urandom_range(1, 4));
      fork
        run_master(0, d0, n0, 32'h0, 2, 32'h0, 1'b1, 1'b0);
        run_master(1, d1, n1, 32'h0, 2, 32'h0, 1'b1, 1'b0);
      join
    end

    // Reset while m1 owns the bus with stb high.
    slave_mute = 1'b1;
    @(posedge clk);
    #1;
    madr[1] = 32'h0000_7777; mdat[1] = 32'h0000_1111; msel[1] = 4'hF; mwe[1] = 1'b1;
    mcyc[1] = 1'b1; mstb[1] = 1'b1;
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (gnt_o != 2'b10 && n < 10);
    end
    chk("rst_pre_gnt", 160'(gnt_o), 160'(2'b10));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 160'({gnt_o, timeout_o, m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o}), 160'(0));
    chk("rst_async_bus", 160'({s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o}), 160'(0));
    @(posedge clk);
    #1;
    mcyc[1] = 1'b0; mstb[1] = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    slave_mute = 1'b0;

    // Tie again after the second reset: m0 wins.
    fork
      run_master(0, 0, 2, 32'h0000_8000, 0, 32'h0, 1'b0, 1'b0);
      run_master(1, 0, 2, 32'h0000_9000, 1, 32'h0000_ABCD, 1'b0, 1'b0);
    join

`ifdef WB_ARB_TIMEOUT_EN
    // Silent slave: forced completion after TCYC stalled stb cycles.
    slave_mute = 1'b1;
    run_master(0, 0, 1, 32'h0000_5000, 0, 32'h0, 1'b0, 1'b1);
    slave_mute = 1'b0;
`endif

    repeat (4) @(posedge clk);
    chk("q0_drained", 160'(q0.size()), 160'(0));
    chk("q1_drained", 160'(q1.size()), 160'(0));
    chk("timeout_pulses", 160'(to_seen), 160'(TO_EN ? 1 : 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
